// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor.
// The FSM walks IDLE -> SHIFT (WIDTH cycles) -> DONE -> IDLE.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub.sv
// Full subtractor slice made of two chained half subtractors: d = x - y - bin.
// Purely combinational, so there is no latency and no backpressure.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_sub u_hs0 (.x(x),  .y(y),   .d(d1), .bout(b1));
    half_sub u_hs1 (.x(d1), .y(bin), .d(d),  .bout(b2));

    assign bout = b1 | b2;

endmodule

// File: rtl/half_sub.sv
// Half subtractor: d = x - y for single bits, with borrow out.
// Purely combinational, so there is no latency and no backpressure.
module half_sub (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bout
);

    assign d    = x ^ y;
    assign bout = ~x & y;

endmodule

// File: rtl/serial_sub.sv
// LSB-first bit-serial a - b: WIDTH edges from accept to a one-cycle done pulse.
// No queuing: start is only sampled while ready=1, so requests made while busy are dropped.
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic             slice_d;
    logic             slice_bout;
    logic             last_bit;

    full_sub u_slice (
        .x   (a_sh_q[0]),
        .y   (b_sh_q[0]),
        .bin (borrow_q),
        .d   (slice_d),
        .bout(slice_bout)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            SHIFT: begin
                a_sh_d            = a_sh_q >> 1;
                b_sh_d            = b_sh_q >> 1;
                diff_d            = diff_q >> 1;
                diff_d[WIDTH-1]   = slice_d;
                borrow_d          = slice_bout;
                cnt_d             = cnt_q + 1'b1;
                // Result borrow is latched only on the final bit so it stays stable afterwards.
                if (last_bit) borrow_out_d = slice_bout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    always_comb begin
        ready      = (state_q == IDLE);
        busy       = (state_q == SHIFT);
        done       = (state_q == DONE);
        diff       = diff_q;
        borrow_out = borrow_out_q;
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: an 8-bit instance with directed and random operations,
// plus a 1-bit instance for the degenerate width.
module tb_serial_sub;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       ready, busy, done, borrow_out;
    logic [7:0] diff;

    logic       start1;
    logic [0:0] a1, b1;
    logic       ready1, busy1, done1, borrow1;
    logic [0:0] diff1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_done = -1;
    bit   cont_mode = 1'b0;
    exp_t q[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_sub #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .ready(ready1), .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: unsigned subtraction modulo 2^8, borrow when a < b.
    function automatic exp_t model8(input logic [7:0] x, input logic [7:0] y, input int acc);
        exp_t e;
        e.d   = 8'(int'(x) - int'(y) + 256);
        e.bo  = (x < y);
        e.acc = acc;
        return e;
    endfunction

    function automatic exp_t model1(input logic x, input logic y, input int acc);
        exp_t e;
        e.d   = 8'((int'(x) - int'(y) + 2) % 2);
        e.bo  = (x < y);
        e.acc = acc;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        chk("state_onehot", $onehot({ready, busy, done}), 1);
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("diff", diff, e.d);
                chk("borrow_out", borrow_out, e.bo);
                chk("latency", cyc - e.acc, 8);
            end
            if (cont_mode && last_done >= 0) chk("done_spacing", cyc - last_done, 10);
            last_done = cyc;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) begin
                chk("unexpected_done_w1", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("diff_w1", diff1, e.d[0]);
                chk("borrow_w1", borrow1, e.bo);
                chk("latency_w1", cyc - e.acc, 1);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || !ready) chk("idle_timeout", 0, 1);
    endtask

    // Called at a negedge; the operation is accepted on the following posedge.
    task automatic issue(input logic [7:0] x, input logic [7:0] y);
        wait_ready();
        a = x;
        b = y;
        start = 1'b1;
        q.push_back(model8(x, y, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        int guard;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_borrow", borrow_out, 0);
        rst = 1'b0;
        @(negedge clk);

        issue(8'h5A, 8'h3C); wait_idle();
        issue(8'h3C, 8'h5A); wait_idle();
        issue(8'h00, 8'h01); wait_idle();
        issue(8'hFF, 8'hFF); wait_idle();

        // Start pulse during SHIFT must be ignored; result stays held afterwards.
        issue(8'h10, 8'h01);
        repeat (2) @(negedge clk);
        chk("busy_in_shift", busy, 1);
        a = 8'h00; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("held_diff", diff, 8'h0F);
        chk("held_borrow", borrow_out, 0);
        chk("held_ready", ready, 1);

        // Reset in the middle of an operation discards it.
        issue(8'h77, 8'h12);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        q.delete();
        rst = 1'b0;
        chk("midrst_ready", ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_diff", diff, 8'h00);
        chk("midrst_borrow", borrow_out, 0);
        repeat (20) @(negedge clk);

        // start held high with operands changing every cycle.
        last_done = -1;
        cont_mode = 1'b1;
        n = 0;
        guard = 0;
        start = 1'b1;
        while (n < 1000 && guard < 20000) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (ready) begin
                q.push_back(model8(a, b, cyc + 1));
                n++;
            end
            @(negedge clk);
            guard++;
        end
        if (n < 1000) chk("cont_timeout", n, 1000);
        start = 1'b0;
        wait_idle();
        cont_mode = 1'b0;

        // Single-bit build: all four operand pairs.
        for (int i = 0; i < 4; i++) begin
            int k = 0;
            while (!ready1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("ready_w1", ready1, 1);
            a1 = 1'(i >> 1);
            b1 = 1'(i);
            start1 = 1'b1;
            q1.push_back(model1(a1[0], b1[0], cyc + 1));
            @(negedge clk);
            start1 = 1'b0;
            repeat (4) @(negedge clk);
        end
        chk("w1_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
